// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encodings and latency helpers.
// The divider build option is ALU_SEQ_DIV_EN (see alu_seq.sv).
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_RUN  = 2'd1,
    DV_FIX  = 2'd2
  } div_state_t;

  // Cycles from acceptance to done, counting the start cycle as cycle 0.
  function automatic int mul_cyc(input int width);
    return width + 1;
  endfunction

  function automatic int div_cyc(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Iterative signed non-restoring divider: WIDTH iterations on magnitudes, then one
// cycle of remainder correction and sign fix. Quotient truncates, remainder follows dividend.
module alu_seq_div
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW       = $clog2(WIDTH);
  localparam int DIV_ITER = div_cyc(WIDTH) - 2;

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH+1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_dvs_ext;
  logic [WIDTH+1:0] w_step;
  logic [WIDTH-1:0] w_rem_mag;

  assign w_mag_a   = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_mag_b   = i_b[WIDTH-1] ? -i_b : i_b;
  assign w_shift   = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
  assign w_dvs_ext = {2'b00, r_dvs};
  // Sign of the partial remainder picks add or subtract; it never needs restoring.
  assign w_step    = r_rem[WIDTH+1] ? (w_shift + w_dvs_ext) : (w_shift - w_dvs_ext);
  assign w_rem_mag = r_rem[WIDTH-1:0] + (r_rem[WIDTH+1] ? r_dvs : {WIDTH{1'b0}});

  assign o_done = (r_state == DV_FIX);
  assign o_quo  = r_neg_q ? -r_quo : r_quo;
  assign o_rem  = r_neg_r ? -w_rem_mag : w_rem_mag;

  // Divider sequencing and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DV_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        DV_IDLE: begin
          if (i_start) begin
            r_state <= DV_RUN;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_neg_r <= i_a[WIDTH-1];
          end
        end
        DV_RUN: begin
          r_rem <= w_step;
          r_quo <= {r_quo[WIDTH-2:0], ~w_step[WIDTH+1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DIV_ITER - 1)) begin
            r_state <= DV_FIX;
          end
        end
        DV_FIX:  r_state <= DV_IDLE;
        default: r_state <= DV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic ops, radix-2 Booth multiply,
// and (when ALU_SEQ_DIV_EN is defined) an iterative signed divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z_lo,
  output logic [WIDTH-1:0] Z_hi,
  output logic             div_zero
);

  localparam int MUL_ITER = mul_cyc(WIDTH) - 1;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH+1:0] r_prod;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_z_lo;
  logic [WIDTH-1:0]   r_z_hi;
  logic               r_div_zero;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_div_iter;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_booth_hi;
  logic [WIDTH:0]     w_mcand;
  logic [WIDTH:0]     w_booth_sum;
  logic [2*WIDTH+1:0] w_booth_next;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic               w_res_dz;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_is_mul   = (r_op == OP_MUL);
  assign w_div_iter = w_is_div && (r_b != '0);
  assign w_sh       = r_b[SHW-1:0];

`ifdef ALU_SEQ_DIV_EN
  logic w_div_start;
  assign w_div_start = w_accept && (operation == OP_DIV) && (B != '0);
  assign w_is_div    = (r_op == OP_DIV);

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .rst     (clr),
    .i_start (w_div_start),
    .i_a     (A),
    .i_b     (B),
    .o_done  (w_div_done),
    .o_quo   (w_div_quo),
    .o_rem   (w_div_rem)
  );
`else
  assign w_is_div   = 1'b0;
  assign w_div_done = 1'b0;
  assign w_div_quo  = '0;
  assign w_div_rem  = '0;
`endif

  // Booth register layout: {hi (WIDTH+1, sign-extended), multiplier (WIDTH), q(-1)}.
  assign w_booth_hi   = r_prod[2*WIDTH+1:WIDTH+1];
  assign w_mcand      = {r_a[WIDTH-1], r_a};
  assign w_booth_next = {w_booth_sum[WIDTH], w_booth_sum, r_prod[WIDTH:1]};

  // Booth partial-product selection from the current bit pair.
  always_comb begin
    w_booth_sum = w_booth_hi;
    case (r_prod[1:0])
      2'b01:   w_booth_sum = w_booth_hi + w_mcand;
      2'b10:   w_booth_sum = w_booth_hi - w_mcand;
      default: w_booth_sum = w_booth_hi;
    endcase
  end

  // Result selection for the cycle that moves EXEC to DONE.
  always_comb begin
    w_res_lo = '0;
    w_res_hi = '0;
    w_res_dz = 1'b0;
    if (w_is_mul) begin
      {w_res_hi, w_res_lo} = w_booth_next[2*WIDTH:1];
    end else if (w_is_div) begin
      if (r_b == '0) begin
        w_res_lo = '1;
        w_res_hi = r_a;
        w_res_dz = 1'b1;
      end else begin
        w_res_lo = w_div_quo;
        w_res_hi = w_div_rem;
      end
    end else begin
      case (r_op)
        OP_ADD:  w_res_lo = r_a + r_b;
        OP_SUB:  w_res_lo = r_a - r_b;
        OP_SHR:  w_res_lo = r_a >> w_sh;
        OP_SHRA: w_res_lo = $signed(r_a) >>> w_sh;
        OP_SHL:  w_res_lo = r_a << w_sh;
        OP_ROR:  w_res_lo = (r_a >> w_sh) | (r_a << (WIDTH - int'(w_sh)));
        OP_ROL:  w_res_lo = (r_a << w_sh) | (r_a >> (WIDTH - int'(w_sh)));
        OP_AND:  w_res_lo = r_a & r_b;
        OP_OR:   w_res_lo = r_a | r_b;
        OP_NEG:  w_res_lo = -r_a;
        OP_NOT:  w_res_lo = ~r_a;
        default: w_res_lo = '0;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_EXEC;
        else       w_next = ST_IDLE;
      end
      ST_EXEC: begin
        if (w_is_mul) begin
          if (r_cnt == SHW'(MUL_ITER - 1)) w_next = ST_DONE;
          else                             w_next = ST_EXEC;
        end else if (w_div_iter) begin
          if (w_div_done) w_next = ST_DONE;
          else            w_next = ST_EXEC;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Operand latches, Booth iteration and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_z_lo     <= '0;
      r_z_hi     <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_busy <= (w_next == ST_EXEC);
      r_done <= (w_next == ST_DONE);
      if (w_accept) begin
        r_op       <= operation;
        r_a        <= A;
        r_b        <= B;
        r_cnt      <= '0;
        r_prod     <= {{(WIDTH+1){1'b0}}, B, 1'b0};
        r_div_zero <= 1'b0;
      end else if (r_state == ST_EXEC) begin
        if (w_is_mul) begin
          r_prod <= w_booth_next;
          r_cnt  <= r_cnt + SHW'(1);
        end
        if (w_next == ST_DONE) begin
          r_z_lo     <= w_res_lo;
          r_z_hi     <= w_res_hi;
          r_div_zero <= w_res_dz;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign Z_lo     = r_z_lo;
  assign Z_hi     = r_z_hi;
  assign div_zero = r_div_zero;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle, parametrised successor to the combinational datapath ALU.
- Same 5-bit opcode map and Z_lo/Z_hi result pair, but with a start/done handshake and arbitrary WIDTH.
- Iterative signed multiply (radix-2 Booth) and signed non-restoring divide replace single-cycle array logic.
- Sits between the register-file operand latches and the Z register pair in the CPU datapath; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand and result half width; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount field width taken from B[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- start  in  1  request; accepted only when busy=0.
- operation  in  5  opcode, sampled with start.
- A  in  WIDTH  operand A, sampled with start.
- B  in  WIDTH  operand B / shift amount, sampled with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when the result is valid.
- Z_lo  out  WIDTH  low result / quotient.
- Z_hi  out  WIDTH  high result / remainder.
- div_zero  out  1  set with done when DIV has B=0; held until next acceptance.

Behaviour:
- Reset (async, clr=1): state=IDLE; busy=0; done=0; Z_lo=0; Z_hi=0; div_zero=0; iteration counter=0. A clr mid-operation aborts the operation; no done is issued.
- Opcodes:
  - ADD 00011, SUB 00100: Z_lo=A±B mod 2^WIDTH.
  - SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001: shift or rotate A by B[SHW-1:0].
  - AND 01010, OR 01011.
  - MUL 01111, DIV 10000.
  - NEG 10001: Z_lo=-A. NOT 10010: Z_lo=~A.
- Z_hi=0 for every single-cycle op. Unlisted opcodes give Z_lo=Z_hi=0 with a normal single-cycle done.
- States IDLE -> EXEC -> DONE -> IDLE; MUL and DIV loop in EXEC for WIDTH cycles.
- Acceptance: edge with start=1 and state IDLE. Operands and opcode are latched; busy rises next cycle.
- Single-cycle ops: one EXEC cycle; done asserted in the 2nd cycle after acceptance.
- MUL: signed × signed; {Z_hi,Z_lo} = full 2*WIDTH product. Radix-2 Booth, one bit per cycle; done WIDTH+1 cycles after acceptance.
- DIV: signed truncating division. Z_lo=quotient, Z_hi=remainder, remainder sign follows the dividend. Non-restoring, WIDTH iterations plus one correction/sign-fix cycle; done WIDTH+2 cycles after acceptance.
- DIV with B=0: skips iteration; done 2 cycles after acceptance; Z_lo = all ones; Z_hi=A; div_zero=1.
- Special case: DIV of the most negative value by -1 gives Z_lo = most negative value, Z_hi=0, no flag.
- start while busy is ignored; no queueing.
- start in the same cycle as done is not accepted (state is DONE). Earliest next acceptance is the cycle after done.
- Z_lo/Z_hi/div_zero update only on done and hold until the next done.

Optional Feature:
- ALU_SEQ_DIV_EN.
- Defined: DIV behaves as above.
- Undefined: no divider datapath is instantiated. Opcode 10000 is treated as unlisted: single-cycle, Z_lo=Z_hi=0, div_zero stays 0.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams (OP_ADD … OP_NOT, 5-bit);
  - the FSM state encodings;
  - the latency constants MUL_CYC=WIDTH+1 and DIV_CYC=WIDTH+2 as functions of WIDTH.
- One sub-module, alu_seq_div, contains the iterative signed divider (start/done, quotient, remainder, WIDTH param).
- Only alu_seq_div is gated by ALU_SEQ_DIV_EN.
- Booth multiply and single-cycle ops stay in alu_seq.

Test Plan:
- Single-cycle ops (WIDTH=32): ADD 5,3 -> Z_lo=8. SUB 10,3 -> 7. AND 12,5 -> 4. OR 12,5 -> 13. NOT 12 -> 0xFFFFFFF3. NEG 10 -> 0xFFFFFFF6. Each has done exactly 2 cycles after start, busy high for 1 cycle.
- Shifts and rotates: SHRA 0x80000008 by 3 -> 0xF0000001. SHR same -> 0x10000001. ROL 0x80000000 by 1 -> 1. ROR 1 by 1 -> 0x80000000. SHL 1 by 31 -> 0x80000000.
- MUL: 6×3 -> Z_lo=18, Z_hi=0. -7×3 -> Z_hi=0xFFFFFFFF, Z_lo=0xFFFFFFEB. 0x7FFFFFFF squared -> {Z_hi,Z_lo}=0x3FFFFFFF00000001. Each has done at cycle 33.
- DIV: 10/2 -> 5 r0. -7/2 -> Z_lo=-3, Z_hi=-1. 10/0 -> Z_lo=0xFFFFFFFF, Z_hi=10, div_zero=1, done at cycle 2. Normal divides have done at cycle 34. With ALU_SEQ_DIV_EN undefined: 10/2 -> 0,0, done at cycle 2.
- Handshake: start held high through a MUL -> exactly one done. Re-accept the cycle after done -> second result correct. Outputs stable between dones.
- Reset mid-MUL at cycle 10: all outputs 0 immediately (async); no done. A fresh ADD afterwards completes normally.
